hazard_scoreboard: RTL and testbench

- Issue-stage scheduler for the register files and the single shared writeback port.
- Tracks every in-flight register write with the latency decode reports (multi-cycle loads, FPU add/sub/inv/sqrt).
- Holds the decode stage when an instruction would read a not-yet-ready register, overtake a pending write (WAW), or collide on the writeback port.
- Sits between decode and execute; the pipeline advances decode only when stall is low.

---
 rtl/hazard_scoreboard.sv | 89 ++++++++
 tb/tb_hazard_scoreboard.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: tracks in-flight register writes and writeback-port claims, stalls decode on RAW/WAW/port conflicts.
// Optional stall statistics counter is built when HAZARD_SCOREBOARD_STATS_EN is defined.
module hazard_scoreboard #(
  parameter int NREG    = 64,
  parameter int MAXWAIT = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [1:0]  issue_rw,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  issue_wait,
  input  logic [5:0]  src_rs,
  input  logic [5:0]  src_rt,
  input  logic        use_rs,
  input  logic        use_rt,
  input  logic        flush,
  output logic        stall,
  output logic        issue_fire,
  output logic [6:0]  pending_cnt,
  output logic [31:0] stall_cycles
);

  logic [4:0]       cnt_q [NREG];
  logic [4:0]       cnt_d [NREG];
  logic [MAXWAIT:0] wb_slot_q, wb_slot_d;
  logic [6:0]       pending_cnt_q, pending_cnt_d;

  logic [5:0] dst;
  logic       has_dst;
  logic       raw, waw, port;

  // GPR 0 is hardwired, so a write to it is never recorded and id 0 never stalls a reader.
  assign dst     = {issue_rw == 2'b10, issue_rd};
  assign has_dst = (issue_rw == 2'b10) || (issue_rw == 2'b01 && issue_rd != 5'd0);

  assign raw  = (use_rs && src_rs != 6'd0 && cnt_q[src_rs] != 5'd0) ||
                (use_rt && src_rt != 6'd0 && cnt_q[src_rt] != 5'd0);
  assign waw  = has_dst && (cnt_q[dst] > issue_wait);
  assign port = has_dst && wb_slot_q[issue_wait];

  assign stall       = issue_valid && !flush && (raw || waw || port);
  assign issue_fire  = issue_valid && !flush && !stall;
  assign pending_cnt = pending_cnt_q;

  // NOTE: every variable gets its default before any conditional update, so no latch is inferred.
  always_comb begin
    wb_slot_d     = wb_slot_q >> 1;
    pending_cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i]      = (cnt_q[i] != 5'd0) ? cnt_q[i] - 5'd1 : 5'd0;
      pending_cnt_d = pending_cnt_d + 7'(cnt_q[i] != 5'd0);
    end
    // A new issue overrides the decrement of its destination entry.
    if (issue_fire && has_dst && issue_wait != 5'd0) begin
      cnt_d[dst]                   = issue_wait;
      wb_slot_d[issue_wait - 5'd1] = 1'b1;
    end
  end

  // NOTE: the countdown array is plain flops, so it is cleared on reset like any other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      wb_slot_q     <= '0;
      pending_cnt_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      wb_slot_q     <= wb_slot_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles_q <= '0;
    else if (stall && stall_cycles_q != 32'hFFFF_FFFF)
      stall_cycles_q <= stall_cycles_q + 32'd1;
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic against
// an absolute-time reference model (per-register ready cycle, set of claimed writeback cycles).
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [1:0]  issue_rw;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_wait;
  logic [5:0]  src_rs;
  logic [5:0]  src_rt;
  logic        use_rs;
  logic        use_rt;
  logic        flush;
  logic        stall;
  logic        issue_fire;
  logic [6:0]  pending_cnt;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_rw     (issue_rw),
    .issue_rd     (issue_rd),
    .issue_wait   (issue_wait),
    .src_rs       (src_rs),
    .src_rt       (src_rt),
    .use_rs       (use_rs),
    .use_rt       (use_rt),
    .flush        (flush),
    .stall        (stall),
    .issue_fire   (issue_fire),
    .pending_cnt  (pending_cnt),
    .stall_cycles (stall_cycles)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cycle at which each register becomes readable, and absolute cycles
  // on which the writeback port is already taken.
  int cyc        = 0;
  int free_at [64];
  bit claimed [int];
  int exp_pend   = 0;
  int exp_stalls = 0;
  logic last_stall, last_fire;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rem(input int r);
    return (free_at[r] > cyc) ? free_at[r] - cyc : 0;
  endfunction

  task automatic step(input logic v, input logic [1:0] rw, input logic [4:0] rd, input logic [4:0] w,
                      input logic [5:0] rs, input logic [5:0] rt, input logic urs, input logic urt,
                      input logic fl);
    int dsti;
    int np;
    bit hd, raw, waw, port, es, ef;
    @(negedge clk);
    issue_valid = v;  issue_rw = rw;  issue_rd = rd;  issue_wait = w;
    src_rs = rs;  src_rt = rt;  use_rs = urs;  use_rt = urt;  flush = fl;
    #1;
    dsti = (rw == 2'b10) ? 32 + int'(rd) : int'(rd);
    hd   = (rw == 2'b10) || (rw == 2'b01 && rd != 5'd0);
    raw  = (urs && rs != 6'd0 && rem(int'(rs)) > 0) || (urt && rt != 6'd0 && rem(int'(rt)) > 0);
    waw  = hd && (rem(dsti) > int'(w));
    port = hd && claimed.exists(cyc + int'(w));
    es   = v && !fl && (raw || waw || port);
    ef   = v && !fl && !es;
    check("stall", stall, es);
    check("issue_fire", issue_fire, ef);
    check("pending_cnt", pending_cnt, exp_pend);
`ifdef HAZARD_SCOREBOARD_STATS_EN
    check("stall_cycles", stall_cycles, exp_stalls);
`endif
    last_stall = stall;
    last_fire  = issue_fire;
    np = 0;
    for (int r = 0; r < 64; r++) if (rem(r) > 0) np++;
    if (ef && hd && w != 5'd0) begin
      free_at[dsti]         = cyc + 1 + int'(w);
      claimed[cyc + int'(w)] = 1'b1;
    end
    if (es) exp_stalls++;
    exp_pend = np;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Re-presents one instruction until it fires (bounded) and checks how many cycles it was held.
  task automatic hold_until_fire(input string tag, input logic [1:0] rw, input logic [4:0] rd,
                                 input logic [4:0] w, input logic [5:0] rs, input logic [5:0] rt,
                                 input logic urs, input logic urt, input int exp_n);
    int n = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b1, rw, rd, w, rs, rt, urs, urt, 1'b0);
      if (last_fire) break;
      if (last_stall) n++;
    end
    check(tag, n, exp_n);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_pending", pending_cnt, 7'd0);
    check("rst_stall", stall, 1'b0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
    check("rst_stall_cycles", stall_cycles, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    for (int r = 0; r < 64; r++) free_at[r] = 0;
    claimed.delete();
    exp_pend   = 0;
    exp_stalls = 0;
  endtask

  initial begin
    logic [1:0] r_rw;
    logic [4:0] r_rd, r_w;
    logic [5:0] r_rs, r_rt;

    for (int r = 0; r < 64; r++) free_at[r] = 0;
    rst = 1'b1;
    issue_valid = 1'b0; issue_rw = 2'b00; issue_rd = 5'd0; issue_wait = 5'd0;
    src_rs = 6'd0; src_rt = 6'd0; use_rs = 1'b0; use_rt = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, and a ready instruction right after release.
    step(1'b1, 2'b01, 5'd7, 5'd0, 6'd5, 6'd6, 1'b1, 1'b1, 1'b0);

    // Load-use: wait=1 load to r5, dependent add held exactly one cycle.
    step(1'b1, 2'b01, 5'd5, 5'd1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    hold_until_fire("load_use_stalls", 2'b00, 5'd0, 5'd0, 6'd5, 6'd0, 1'b1, 1'b0, 1);
    idle(3);

    // FPU RAW: fadd f3 wait=5, reader of 6'h23 on rt held five cycles.
    step(1'b1, 2'b10, 5'd3, 5'd5, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    hold_until_fire("fpu_raw_stalls", 2'b00, 5'd0, 5'd0, 6'd0, 6'h23, 1'b0, 1'b1, 5);
    idle(8);

    // WAW: wait=5 then wait=1 to the same FPR waits until the older countdown drops to 1.
    step(1'b1, 2'b10, 5'd1, 5'd5, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    hold_until_fire("waw_stalls", 2'b10, 5'd1, 5'd1, 6'd0, 6'd0, 1'b0, 1'b0, 4);
    idle(8);

    // Writeback port: wait=4 issued one cycle after a wait=5 op collides for one cycle.
    step(1'b1, 2'b10, 5'd4, 5'd5, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    hold_until_fire("port_stalls", 2'b10, 5'd2, 5'd4, 6'd0, 6'd0, 1'b0, 1'b0, 1);
    idle(8);

    // GPR 0 is never tracked; flushed ops are never recorded.
    step(1'b1, 2'b01, 5'd0, 5'd1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 2'b10, 5'd5, 5'd5, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 2'b00, 5'd0, 5'd0, 6'h25, 6'd0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Reset with three writes outstanding.
    step(1'b1, 2'b01, 5'd9,  5'd20, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b10, 5'd9,  5'd25, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b10, 5'd10, 5'd30, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 5'd0,  5'd0,  6'd9, 6'h29, 1'b1, 1'b1, 1'b0);
    do_reset();
    step(1'b1, 2'b10, 5'd9, 5'd0, 6'd9, 6'h29, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Random traffic on a small register window so hazards are frequent.
    for (int i = 0; i < 800; i++) begin
      r_rw = 2'($urandom_range(0, 3));
      r_rd = 5'($urandom_range(0, 3));
      r_w  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      r_rs = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
      r_rt = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
      step(1'($urandom_range(0, 4) != 0), r_rw, r_rd, r_w, r_rs, r_rt,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
      if (i == 400) do_reset();
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
